// File: rtl/bracket_pkg.sv
// Shared constants, state encoding and character classification for bracket_seq_checker.
package bracket_pkg;

    localparam logic [6:0] CH_LPAREN  = 7'h28;
    localparam logic [6:0] CH_RPAREN  = 7'h29;
    localparam logic [6:0] CH_LSQUARE = 7'h5B;
    localparam logic [6:0] CH_RSQUARE = 7'h5D;
    localparam logic [6:0] CH_LCURLY  = 7'h7B;
    localparam logic [6:0] CH_RCURLY  = 7'h7D;

    typedef enum logic [1:0] {
        BR_PAREN  = 2'd0,
        BR_SQUARE = 2'd1,
        BR_CURLY  = 2'd2
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BAL  = 2'd1,
        ST_OPEN = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef struct packed {
        logic     is_open;
        logic     is_close;
        br_type_e kind;
    } char_class_t;

    // Square and curly brackets are only recognised when multi_en is set.
    function automatic char_class_t classify(input logic [6:0] ch, input logic multi_en);
        char_class_t c;
        c.is_open  = 1'b0;
        c.is_close = 1'b0;
        c.kind     = BR_PAREN;
        case (ch)
            CH_LPAREN:  c.is_open = 1'b1;
            CH_RPAREN:  c.is_close = 1'b1;
            CH_LSQUARE: begin c.is_open  = multi_en; c.kind = BR_SQUARE; end
            CH_RSQUARE: begin c.is_close = multi_en; c.kind = BR_SQUARE; end
            CH_LCURLY:  begin c.is_open  = multi_en; c.kind = BR_CURLY;  end
            CH_RCURLY:  begin c.is_close = multi_en; c.kind = BR_CURLY;  end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bracket_stack.sv
// LIFO of bracket type codes with clear; ptr doubles as the nesting depth.
module bracket_stack
    import bracket_pkg::*;
#(
    parameter  int unsigned MAX_DEPTH = 16,
    localparam int unsigned PTR_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  br_type_e         push_type,
    output logic             full,
    output logic             empty,
    output br_type_e         top,
    output logic [PTR_W-1:0] ptr
);

    localparam int unsigned IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    br_type_e         mem_q [MAX_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;

    assign full  = (ptr_q == PTR_W'(MAX_DEPTH));
    assign empty = (ptr_q == '0);
    assign top   = empty ? BR_PAREN : mem_q[IDX_W'(ptr_q - PTR_W'(1))];
    assign ptr   = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clear)              ptr_d = '0;
        else if (push && !full) ptr_d = ptr_q + PTR_W'(1);
        else if (pop && !empty) ptr_d = ptr_q - PTR_W'(1);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    // Contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) mem_q[IDX_W'(ptr_q)] <= push_type;
    end

endmodule

// File: rtl/bracket_seq_checker.sv
// Bracket-balance recognizer with per-terminator verdict.
// BRACKET_MULTI_TYPE_EN selects ( [ { with a type stack; otherwise ( only with a depth counter.
module bracket_seq_checker
    import bracket_pkg::*;
#(
    parameter  int unsigned        DATA_W    = 8,
    parameter  int unsigned        MAX_DEPTH = 16,
    parameter  logic [DATA_W-1:0]  TERM_CHAR = DATA_W'(8'h3B),
    localparam int unsigned        DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [DATA_W-1:0]  in,
    input  logic               in_valid,
    output logic               out,
    output logic [DEPTH_W-1:0] depth,
    output logic               err,
    output logic               done,
    output logic               ok
);

`ifdef BRACKET_MULTI_TYPE_EN
    localparam logic MULTI_EN = 1'b1;
`else
    localparam logic MULTI_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               out_q, out_d, err_q, err_d, done_q, done_d, ok_q, ok_d;
    char_class_t        cls_c;
    logic               is_term_c, full_c, empty_c, mismatch_c;
    logic               push_c, pop_c, clear_c;
    logic [DEPTH_W-1:0] depth_c;
    logic               unused_c;

    assign cls_c     = classify(in[6:0], MULTI_EN);
    assign is_term_c = (in[6:0] == TERM_CHAR[6:0]);
    assign unused_c  = ^in[DATA_W-1:7];

`ifdef BRACKET_MULTI_TYPE_EN
    br_type_e top_c;

    bracket_stack #(.MAX_DEPTH(MAX_DEPTH)) u_stack (
        .clk       (clk),
        .clr       (clr),
        .push      (push_c),
        .pop       (pop_c),
        .clear     (clear_c),
        .push_type (cls_c.kind),
        .full      (full_c),
        .empty     (empty_c),
        .top       (top_c),
        .ptr       (depth_c)
    );

    assign mismatch_c = (top_c != cls_c.kind);
`else
    logic [DEPTH_W-1:0] depth_q, depth_d;

    // Single bracket type: only the depth needs remembering.
    always_comb begin
        depth_d = depth_q;
        if (clear_c)     depth_d = '0;
        else if (push_c) depth_d = depth_q + DEPTH_W'(1);
        else if (pop_c)  depth_d = depth_q - DEPTH_W'(1);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) depth_q <= '0;
        else      depth_q <= depth_d;
    end

    assign depth_c    = depth_q;
    assign full_c     = (depth_q == DEPTH_W'(MAX_DEPTH));
    assign empty_c    = (depth_q == '0);
    assign mismatch_c = (cls_c.kind != BR_PAREN);
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        clear_c = 1'b0;
        if (in_valid) begin
            if (is_term_c) begin
                done_d  = 1'b1;
                ok_d    = (state_q == ST_BAL);
                clear_c = 1'b1;
                state_d = ST_IDLE;
            end else if (state_q != ST_ERR) begin
                if (cls_c.is_open) begin
                    if (full_c) begin
                        state_d = ST_ERR;
                    end else begin
                        push_c  = 1'b1;
                        state_d = ST_OPEN;
                    end
                end else if (cls_c.is_close) begin
                    if (empty_c || mismatch_c) begin
                        state_d = ST_ERR;
                    end else begin
                        pop_c = 1'b1;
                        if (depth_c == DEPTH_W'(1)) state_d = ST_BAL;
                    end
                end
            end
        end
        out_d = (state_d == ST_BAL);
        err_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    assign out   = out_q;
    assign err   = err_q;
    assign done  = done_q;
    assign ok    = ok_q;
    assign depth = depth_c;

endmodule

// File: tb/tb_bracket_seq_checker.sv
// Scoreboard bench for bracket_seq_checker: directed sequences plus random character streams.
module tb_bracket_seq_checker;

    localparam int unsigned MD = 4;
    localparam int unsigned DW = $clog2(MD + 1);
`ifdef BRACKET_MULTI_TYPE_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    in = 8'h00;
    logic          in_valid = 1'b0;
    logic          out, err, done, ok;
    logic [DW-1:0] depth;

    typedef struct {
        bit out;
        int depth;
        bit err;
        bit done;
        bit ok;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   total = 0;
    int   bad = 0;

    // Reference model: open brackets as a queue of type indices.
    int stk[$];
    bit paired;
    bit broken;

    always #5 clk = ~clk;

    bracket_seq_checker #(.DATA_W(8), .MAX_DEPTH(MD), .TERM_CHAR(8'h3B)) dut (
        .clk      (clk),
        .clr      (clr),
        .in       (in),
        .in_valid (in_valid),
        .out      (out),
        .depth    (depth),
        .err      (err),
        .done     (done),
        .ok       (ok)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        stk.delete();
        paired = 1'b0;
        broken = 1'b0;
    endfunction

    function automatic exp_t model_view();
        exp_t e;
        e.out   = !broken && (stk.size() == 0) && paired;
        e.depth = stk.size();
        e.err   = broken;
        e.done  = 1'b0;
        e.ok    = 1'b0;
        return e;
    endfunction

    function automatic int open_type(input logic [6:0] c);
        if (c == 7'h28) return 0;
        if (MULTI && c == 7'h5B) return 1;
        if (MULTI && c == 7'h7B) return 2;
        return -1;
    endfunction

    function automatic int close_type(input logic [6:0] c);
        if (c == 7'h29) return 0;
        if (MULTI && c == 7'h5D) return 1;
        if (MULTI && c == 7'h7D) return 2;
        return -1;
    endfunction

    function automatic exp_t model_step(input logic [7:0] c);
        exp_t e;
        bit   verdict;
        int   ot, ct;
        if (c[6:0] == 7'h3B) begin
            verdict = model_view().out;
            model_reset();
            e      = model_view();
            e.done = 1'b1;
            e.ok   = verdict;
            return e;
        end
        if (!broken) begin
            ot = open_type(c[6:0]);
            ct = close_type(c[6:0]);
            if (ot >= 0) begin
                if (stk.size() == MD) broken = 1'b1;
                else                  stk.push_back(ot);
            end else if (ct >= 0) begin
                if (stk.size() == 0 || stk[$] != ct) begin
                    broken = 1'b1;
                end else begin
                    void'(stk.pop_back());
                    paired = 1'b1;
                end
            end
        end
        return model_view();
    endfunction

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in       = c;
        in_valid = 1'b1;
        sb_q.push_back(model_step(c));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(8'(s[i]));
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in       = 8'($urandom);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        in_valid = 1'b0;
        #2 clr = 1'b0;
        #1;
        check("clr_depth", depth, 0);
        check("clr_err", err, 0);
        check("clr_out", out, 0);
        model_reset();
        last_exp = '{out: 1'b0, depth: 0, err: 1'b0, done: 1'b0, ok: 1'b0};
        @(negedge clk);
        clr = 1'b1;
    endtask

    // Monitor: pops one expectation per consumed character, checks hold otherwise.
    initial begin
        bit   v;
        exp_t e;
        last_exp = '{out: 1'b0, depth: 0, err: 1'b0, done: 1'b0, ok: 1'b0};
        forever begin
            @(posedge clk);
            v = in_valid && clr;
            #1;
            if (!clr) continue;
            if (v) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underrun: output cycle with no expectation at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("out", out, e.out);
                    check("depth", depth, e.depth);
                    check("err", err, e.err);
                    check("done", done, e.done);
                    if (e.done) check("ok", ok, e.ok);
                    last_exp = e;
                end
            end else begin
                check("hold_done", done, 0);
                check("hold_out", out, last_exp.out);
                check("hold_depth", depth, last_exp.depth);
                check("hold_err", err, last_exp.err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        string alpha;
        logic [7:0] c;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_depth", depth, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_ok", ok, 0);
        clr = 1'b1;
        gap(1);

        send_str("([]{});");
        gap(2);
        send_str("(];");
        gap(1);
        send_str(")();");
        gap(1);
        send_str("(((((;");
        gap(1);
        send_str("a");  gap(1);
        send_str("(");  gap(2);
        send_str("b");  gap(1);
        send_str(")");  gap(1);
        send_str("c");  gap(1);
        send_str(";");
        gap(1);
        send_str("((");
        pulse_clr();
        send_str("();");
        send_str("();;");
        send_str(";");
        gap(2);

        alpha = "()[]{};ab((";
        for (int i = 0; i < 1500; i++) begin
            c = 8'(alpha[$urandom_range(0, alpha.len() - 1)]);
            if ($urandom_range(0, 7) == 0) c[7] = 1'b1;
            send(c);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
            if ($urandom_range(0, 199) == 0) pulse_clr();
        end
        gap(3);
        check("sb_left", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bracket_seq_checker.md
# bracket_seq_checker

Parametrised character-stream recognizer for bracket-balanced expressions, the next generation of the project's single-bracket sequence FSM. It consumes one 8-bit ASCII character per accepted cycle, tracks nesting of up to three bracket types on an internal stack of configurable depth, and reports a live "balanced" level plus a per-expression verdict on each terminator character. It sits directly behind the character source (testbench or UART front end) in the P2 datapath experiments.

## Interface
- `DATA_W`, 8: character width; only the low 7 bits are compared against ASCII codes.
- `MAX_DEPTH`, 16: maximum nesting depth; must be ≥ 1.
- `TERM_CHAR`, 8'h3B (`;`): expression terminator.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `clr`  input  1  asynchronous active-low reset.
- `in`  input  DATA_W  character.
- `in_valid`  input  1  `in` is consumed this cycle when high.
- `out`  output  1  current expression is non-empty and balanced.
- `depth`  output  $clog2(MAX_DEPTH+1)  current nesting depth.
- `err`  output  1  current expression has already failed.
- `done`  output  1  one-cycle pulse after a terminator is consumed.
- `ok`  output  1  verdict for that terminator; valid only while `done` is high.

## Operation
- Open characters `(` `[` `{` push a 2-bit type code; close characters `)` `]` `}` pop and compare. All other non-terminator characters are ignored (no state change).
- States: IDLE (nothing bracketed yet), BAL (depth 0, ≥ 1 pair closed), OPEN (depth > 0), ERR.
- IDLE/BAL + open → OPEN, depth 1. OPEN + open → OPEN, depth+1. OPEN + matching close → depth−1; to BAL when depth reaches 0.
- Close while depth = 0 (underflow) → ERR. Close of the wrong type → ERR. Open while depth = MAX_DEPTH (overflow) → ERR; the stack is not written.
- ERR ignores every character except the terminator.
- Terminator from any state: `done`=1 next cycle; `ok`=1 only if the state was BAL; stack is cleared, depth=0, state → IDLE. A terminator in IDLE yields `ok`=0, because an empty expression is not accepted.
- `out` = (state == BAL); `err` = (state == ERR); `depth` is the stack pointer.
- When `in_valid` is low, all state holds and `done` is 0.

## Timing
- All outputs are registered. They reflect a character consumed at edge N from edge N onward, with one cycle of latency, and there is no combinational path from `in` to any output.
- The block accepts one character per cycle with no stall; there is no ready signal.
- Reset values: `out`=0, `depth`=0, `err`=0, `done`=0, `ok`=0, state=IDLE, stack contents don't-care.
- Asserting `clr` mid-expression discards the stack immediately. The first character after deassertion is treated as the start of a new expression.
- Back-to-back terminators each produce a `done` pulse, and the second gives `ok`=0.

## Configuration
- `BRACKET_MULTI_TYPE_EN` defined: three bracket types, stack of 2-bit codes, type-mismatch detection enabled.
- Not defined: only `(` and `)` are recognised, and `[ ] { }` are ignored as ordinary characters. The stack is replaced by a depth counter, with the same overflow and underflow rules and the same `depth` output.

## Structure
- Package `bracket_pkg`: ASCII constants for the six brackets, type codes (PAREN=0, SQUARE=1, CURLY=2), state encoding, and a char-classification function returning {is_open, is_close, type}.
- Sub-module `bracket_stack`: a MAX_DEPTH×2-bit LIFO with push, pop, clear, full, empty, top and ptr. It is instantiated only under `BRACKET_MULTI_TYPE_EN`.

## Test plan
- Reset, then `([]{})` followed by `;` → `depth` goes 1,2,1,2,1,0; `out`=1 after the final `)`; `done`=1 and `ok`=1 on the cycle after `;`.
- `(]` then `;` → `err`=1 after `]`; on terminator `done`=1, `ok`=0; then `depth`=0 and state IDLE.
- `)` first → `err`=1 immediately; a following `()` is ignored; `;` → `ok`=0.
- With MAX_DEPTH=4, five `(` → `depth`=4 and `err`=1 after the fifth; `;` gives `ok`=0.
- `a(b)c` with `in_valid` toggled low between characters, then `;` → letters are ignored, state holds while invalid, `ok`=1.
- Assert `clr` low after `((`, release, then `()` and `;` → `depth` returns to 0 asynchronously and `ok`=1.
